// File: rtl/i2s_receiver_if.sv
// Pin and sample bus of the I2S capture block. The peak meter signals exist only
// when I2S_RX_PEAK_EN is defined.
interface i2s_receiver_if;
  logic        sd_in;
  logic        mclk;
  logic        sclk;
  logic        lrclk;
  logic [15:0] left;
  logic [15:0] right;
  // sample_valid is a one-cycle strobe with no ready: left/right are stable from the
  // strobe until the next latch, and the consumer must take the pair when it sees it.
  logic        sample_valid;
`ifdef I2S_RX_PEAK_EN
  logic        peak_clr;
  logic [15:0] peak;

  modport master (
    input  sd_in, peak_clr,
    output mclk, sclk, lrclk, left, right, sample_valid, peak
  );
  modport slave (
    output sd_in, peak_clr,
    input  mclk, sclk, lrclk, left, right, sample_valid, peak
  );
`else
  modport master (
    input  sd_in,
    output mclk, sclk, lrclk, left, right, sample_valid
  );
  modport slave (
    output sd_in,
    input  mclk, sclk, lrclk, left, right, sample_valid
  );
`endif
endinterface

// File: rtl/i2s_receiver.sv
// I2S master-mode receiver for the Pmod I2S2 ADC: MCLK/SCLK/LRCK generation, SDIN
// deserialisation and left/right latching. Optional peak meter: I2S_RX_PEAK_EN.
module i2s_receiver #(
  parameter int MCLK_HALF = 25,
  parameter int SCLK_HALF = 50,
  parameter int SLOT_BITS = 16
) (
  input logic            clk,
  input logic            rst,
  i2s_receiver_if.master bus
);
  localparam int FRAME_EDGES = 2 * SLOT_BITS;
  localparam int MC_W = (MCLK_HALF > 1) ? $clog2(MCLK_HALF) : 1;
  localparam int SC_W = $clog2(SCLK_HALF);
  localparam int E_W  = $clog2(FRAME_EDGES);
  localparam logic [MC_W-1:0] MC_LAST = MC_W'(MCLK_HALF - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCLK_HALF - 1);

  logic [MC_W-1:0] mclk_cnt_q, mclk_cnt_d;
  logic            mclk_q, mclk_d;
  logic [SC_W-1:0] sclk_cnt_q, sclk_cnt_d;
  logic            sclk_q, sclk_d;
  logic            lrclk_q, lrclk_d;
  logic [E_W-1:0]  e_q, e_d;
  logic [1:0]      sync_q;
  logic [15:0]     shift_q, shift_d;
  logic [15:0]     left_q, left_d;
  logic [15:0]     right_q, right_d;
  logic            valid_q, valid_d;
  logic            armed_q, armed_d;

  logic            sclk_tick, rise, fall;
  logic            cap_left, cap_right, left_latch, right_latch;
  logic [15:0]     shifted;
  int              left_pos, right_pos;

  always_comb begin
    mclk_cnt_d = mclk_cnt_q + MC_W'(1);
    mclk_d     = mclk_q;
    if (mclk_cnt_q == MC_LAST) begin
      mclk_cnt_d = '0;
      mclk_d     = ~mclk_q;
    end
  end

  always_comb begin
    sclk_cnt_d = sclk_cnt_q + SC_W'(1);
    sclk_d     = sclk_q;
    sclk_tick  = 1'b0;
    if (sclk_cnt_q == SC_LAST) begin
      sclk_cnt_d = '0;
      sclk_d     = ~sclk_q;
      sclk_tick  = 1'b1;
    end
  end

  assign rise    = sclk_tick & ~sclk_q;
  assign fall    = sclk_tick & sclk_q;
  assign shifted = {shift_q[14:0], sync_q[1]};

  // Bit position inside the left/right slot, accounting for the one-bit I2S delay
  // and wrapping modulo the frame (the last right bit lands on e=0 when SLOT_BITS=16).
  always_comb begin
    left_pos  = (e_q == '0) ? FRAME_EDGES - 1 : int'(e_q) - 1;
    right_pos = (int'(e_q) > SLOT_BITS) ? int'(e_q) - SLOT_BITS - 1
                                        : int'(e_q) + SLOT_BITS - 1;
  end

  assign cap_left    = rise && (left_pos < 16);
  assign cap_right   = rise && (right_pos < 16);
  assign left_latch  = cap_left && (left_pos == 15);
  assign right_latch = cap_right && (right_pos == 15) && armed_q;

  always_comb begin
    e_d     = e_q;
    lrclk_d = lrclk_q;
    shift_d = shift_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    armed_d = armed_q;
    if (rise) begin
      e_d = (int'(e_q) == FRAME_EDGES - 1) ? '0 : e_q + E_W'(1);
    end
    if (fall) begin
      if (int'(e_q) == SLOT_BITS) begin
        lrclk_d = 1'b1;
      end else if (e_q == '0) begin
        lrclk_d = 1'b0;
      end
    end
    if (cap_left || cap_right) begin
      shift_d = shifted;
    end
    if (left_latch) begin
      left_d  = shifted;
      armed_d = 1'b1;
    end
    // Without a prior full left slot the right latch would expose partial data.
    if (right_latch) begin
      right_d = shifted;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt_q <= '0;
      mclk_q     <= 1'b0;
      sclk_cnt_q <= '0;
      sclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      e_q        <= '0;
      sync_q     <= '0;
      shift_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      mclk_q     <= mclk_d;
      sclk_cnt_q <= sclk_cnt_d;
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      e_q        <= e_d;
      sync_q     <= {sync_q[0], bus.sd_in};
      shift_q    <= shift_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.mclk         = mclk_q;
  assign bus.sclk         = sclk_q;
  assign bus.lrclk        = lrclk_q;
  assign bus.left         = left_q;
  assign bus.right        = right_q;
  assign bus.sample_valid = valid_q;

`ifdef I2S_RX_PEAK_EN
  logic [15:0] peak_q, peak_d, mag;

  // -32768 has no positive 16-bit counterpart, so it saturates to 32767.
  always_comb begin
    mag = shifted;
    if (shifted[15]) begin
      mag = (shifted == 16'h8000) ? 16'h7FFF : (~shifted + 16'd1);
    end
    peak_d = peak_q;
    if (bus.peak_clr) begin
      peak_d = '0;
    end else if ((left_latch || right_latch) && (mag > peak_q)) begin
      peak_d = mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: two instances (SLOT_BITS 16 and 24) fed by a frame-level ADC
// model; expected pairs are queued per frame and checked at each sample_valid.
module tb_i2s_receiver;
  localparam int MH = 25;
  localparam int SH = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  int   cyc = 0;
  int   phase = 1;
  int   checks = 0;
  int   errors = 0;
  int   vcnt [2];

  always #5 clk = ~clk;

  // cyc is the spec's cycle index: 0 in the first period with rst low.
  always @(posedge clk) begin
    rst_s <= rst;
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  function automatic int valid_cycle(input int f, input int sb);
    return SH + 2 * SH * ((2 * f + 1) * sb + 16);
  endfunction

  function automatic int absm(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    if (s < 0) s = -s;
    if (s > 32767) s = 32767;
    return s;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int SB = (g == 0) ? 16 : 24;

    i2s_receiver_if bus_i ();
    i2s_receiver #(.MCLK_HALF(MH), .SCLK_HALF(SH), .SLOT_BITS(SB)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_i)
    );

    logic [63:0] exp_q[$];
    logic [15:0] ls [16];
    logic [15:0] rs [16];

    // ADC model: rise n carries stream bit n-1; slots of SB bits alternate left/right,
    // 16 data bits MSB first then padding ones. Data changes mid-way between rises.
    initial begin : driver
      int n, m, s, pos, fr, ch;
      logic bitv;
      bus_i.sd_in = 1'b0;
`ifdef I2S_RX_PEAK_EN
      bus_i.peak_clr = 1'b0;
`endif
      forever begin
        @(negedge clk);
        if (rst_s) begin
          exp_q.delete();
          for (int i = 0; i < 16; i++) begin
            ls[i] = 16'($urandom_range(0, 65535));
            rs[i] = 16'($urandom_range(0, 65535));
          end
          if (phase == 1) begin
            ls[0] = 16'h1234; rs[0] = 16'hABCD;
            ls[1] = 16'h1234; rs[1] = 16'hABCD;
            ls[2] = 16'h8000; rs[2] = 16'h7FFF;
            ls[3] = 16'h0001; rs[3] = 16'hFFFF;
            ls[4] = 16'h0100; rs[4] = 16'hFE00;
            ls[5] = 16'h8000;
          end
          bus_i.sd_in = 1'b0;
`ifdef I2S_RX_PEAK_EN
          bus_i.peak_clr = 1'b0;
`endif
        end else begin
          n = cyc / (2 * SH);
          m = n - 1;
          bitv = 1'b0;
          if (m >= 0) begin
            s   = m / SB;
            pos = m % SB;
            fr  = s / 2;
            ch  = s % 2;
            if (fr < 16) begin
              if (pos >= 16)    bitv = 1'b1;
              else if (ch == 1) bitv = rs[fr][15-pos];
              else              bitv = ls[fr][15-pos];
              if ((cyc % (2 * SH)) == 0 && ch == 0 && pos == 0)
                exp_q.push_back({32'(valid_cycle(fr, SB)), ls[fr], rs[fr]});
            end
          end
          bus_i.sd_in = bitv;
`ifdef I2S_RX_PEAK_EN
          bus_i.peak_clr = (phase == 1) && (cyc == valid_cycle(3, SB) - 1);
`endif
        end
      end
    end

    initial begin : monitor
      logic [63:0] e;
      logic [15:0] prev_l, prev_r;
      int fidx;
      int peak_m;
      prev_l = '0; prev_r = '0; fidx = 0; peak_m = 0; vcnt[g] = 0;
      forever begin
        @(negedge clk);
        if (rst_s) begin
          chk("rst_mclk", g, bus_i.mclk, 0);
          chk("rst_sclk", g, bus_i.sclk, 0);
          chk("rst_lrclk", g, bus_i.lrclk, 0);
          chk("rst_left", g, bus_i.left, 0);
          chk("rst_right", g, bus_i.right, 0);
          chk("rst_valid", g, bus_i.sample_valid, 0);
`ifdef I2S_RX_PEAK_EN
          chk("rst_peak", g, bus_i.peak, 0);
`endif
          prev_l = '0; prev_r = '0; fidx = 0; peak_m = 0; vcnt[g] = 0;
        end else begin
          chk("mclk", g, bus_i.mclk, (cyc / MH) % 2);
          chk("sclk", g, bus_i.sclk, (cyc / SH) % 2);
          chk("lrclk", g, bus_i.lrclk, (cyc / (2 * SH * SB)) % 2);
          if (bus_i.sample_valid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_valid", g, bus_i.sample_valid, 0);
            end else begin
              e = exp_q.pop_front();
              chk("valid_cycle", g, cyc, e[63:32]);
              chk("left", g, bus_i.left, e[31:16]);
              chk("right", g, bus_i.right, e[15:0]);
`ifdef I2S_RX_PEAK_EN
              if (phase == 1 && fidx == 3) begin
                peak_m = 0;
              end else begin
                if (absm(e[31:16]) > peak_m) peak_m = absm(e[31:16]);
                if (absm(e[15:0]) > peak_m) peak_m = absm(e[15:0]);
              end
              chk("peak", g, bus_i.peak, peak_m);
`endif
              fidx++;
              vcnt[g]++;
            end
          end else begin
            if (bus_i.right != prev_r) chk("right_hold", g, bus_i.right, prev_r);
            if (bus_i.left != prev_l) begin
              if (exp_q.size() > 0) chk("left_latch", g, bus_i.left, exp_q[0][31:16]);
              else                  chk("left_hold", g, bus_i.left, prev_l);
            end
          end
          prev_l = bus_i.left;
          prev_r = bus_i.right;
        end
      end
    end
  end

  task automatic wait_valids(input int target, input int budget);
    int i;
    i = 0;
    while ((vcnt[0] < target || vcnt[1] < target) && i < budget) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (i >= budget) begin
      errors++;
      $display("FAIL valid_timeout: got %0d/%0d pulses expected %0d", vcnt[0], vcnt[1], target);
    end
  endtask

  initial begin
    int i;
    rst = 1'b1;
    phase = 1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    wait_valids(6, 32000);

    phase = 2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    i = 0;
    while (cyc != 2000 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_valids(3, 16000);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
